// File: rtl/bridge_pkg.sv
// bridge_pkg: shared constants and types for the multi-device bridge.
//   NDEV_DEFAULT    - default number of device ports
//   TIMEOUT_DEFAULT - default number of wait cycles before an error response
//   DEV_BASE        - byte base address of each device window (index 0 rightmost)
//   DEV_SIZE        - byte size of each device window
//   state_t         - bridge FSM state encoding
package bridge_pkg;

  localparam int NDEV_DEFAULT    = 3;
  localparam int TIMEOUT_DEFAULT = 15;
  localparam int MAX_DEV         = 8;

  // Windows are 16 bytes apart with 12 usable bytes each. Entries beyond the
  // first three keep the same stride so NDEV can be raised up to MAX_DEV.
  localparam logic [MAX_DEV-1:0][31:0] DEV_BASE = {
    32'h0000_7F70, 32'h0000_7F60, 32'h0000_7F50, 32'h0000_7F40,
    32'h0000_7F30, 32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00
  };
  localparam logic [MAX_DEV-1:0][31:0] DEV_SIZE = {MAX_DEV{32'h0000_000C}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/bridge_addr_decode.sv
// bridge_addr_decode: combinational address decoder.
//   addr - CPU byte address
//   hit  - one-hot device hit vector (word-aligned address inside a window)
//   miss - no device hit
module bridge_addr_decode
  import bridge_pkg::*;
#(
  parameter int NDEV = NDEV_DEFAULT
) (
  input  logic [31:0]     addr,
  output logic [NDEV-1:0] hit,
  output logic            miss
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NDEV; i++) begin
      hit[i] = (addr[1:0] == 2'b00) &&
               (addr >= DEV_BASE[i]) &&
               (addr <= DEV_BASE[i] + DEV_SIZE[i] - 32'd1);
    end
  end

  assign miss = ~|hit;

endmodule

// File: rtl/multi_dev_bridge.sv
// multi_dev_bridge: routes single CPU accesses to one of NDEV devices.
//   clk, reset       - rising-edge clock, asynchronous active-high reset
//   PrAddr/PrWD      - CPU byte address / write data
//   PrReq/PrWE       - access request (sampled in IDLE only) / write select
//   PrRD/PrErr       - registered response data / error, valid with PrDone
//   PrDone           - one-cycle completion pulse
//   PrBusy           - high whenever the FSM is not IDLE
//   DevAddr/DevWD    - latched word address / write data
//   DevWE/DevRE      - one-hot write / read strobes (one ACCESS cycle)
//   DevRD            - flattened device read data, device i at [32i+31:32i]
//   DevAck           - per-device completion
//   state_dbg        - current FSM state
//
// Handshake: the CPU raises PrReq while PrBusy=0; the request is taken on
// that edge and PrReq is ignored until PrDone has pulsed. Toward the device,
// the strobe is a one-cycle command; the selected DevAck may arrive in the
// strobe cycle or any later cycle up to the timeout, and only the DevAck bit
// of the selected device is looked at.
module multi_dev_bridge
  import bridge_pkg::*;
#(
  parameter int NDEV    = NDEV_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       PrAddr,
  input  logic [31:0]       PrWD,
  input  logic              PrReq,
  input  logic              PrWE,
  output logic [31:0]       PrRD,
  output logic              PrDone,
  output logic              PrErr,
  output logic              PrBusy,
  output logic [29:0]       DevAddr,
  output logic [31:0]       DevWD,
  output logic [NDEV-1:0]   DevWE,
  output logic [NDEV-1:0]   DevRE,
  input  logic [32*NDEV-1:0] DevRD,
  input  logic [NDEV-1:0]   DevAck,
  output logic [1:0]        state_dbg
);

  // A zero timeout still needs a one-bit counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NDEV-1:0] sel_q;
  logic            we_q;
  logic [NDEV-1:0] hit;
  logic            miss;
  logic            ack_sel;
  logic [31:0]     rd_sel;

  bridge_addr_decode #(.NDEV(NDEV)) u_decode (
    .addr (PrAddr),
    .hit  (hit),
    .miss (miss)
  );

  // sel_q is one-hot, so masking and OR-reducing picks the selected device.
  assign ack_sel = |(DevAck & sel_q);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (sel_q[i]) rd_sel = rd_sel | DevRD[32*i +: 32];
    end
  end

  assign PrDone    = (state == ST_RESP);
  assign PrBusy    = (state != ST_IDLE);
  assign DevWE     = (state == ST_ACCESS &&  we_q) ? sel_q : '0;
  assign DevRE     = (state == ST_ACCESS && !we_q) ? sel_q : '0;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      DevAddr <= '0;
      DevWD   <= '0;
      PrRD    <= '0;
      PrErr   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (PrReq) begin
            DevAddr <= PrAddr[31:2];
            DevWD   <= PrWD;
            we_q    <= PrWE;
            sel_q   <= hit;
            cnt     <= '0;
            if (miss) begin
              PrRD  <= '0;
              PrErr <= 1'b1;
              state <= ST_RESP;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS, ST_WAIT: begin
          // An ack in the last allowed cycle wins over the timeout.
          if (ack_sel) begin
            PrRD  <= we_q ? 32'd0 : rd_sel;
            PrErr <= 1'b0;
            state <= ST_RESP;
          end else if (cnt == CNT_MAX) begin
            PrRD  <= '0;
            PrErr <= 1'b1;
            state <= ST_RESP;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ST_WAIT;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/multi_dev_bridge.md
MULTI_DEV_BRIDGE -- requirements
Module: multi_dev_bridge

Interface
REQ-001 SHALL have parameter NDEV, default 3: number of device ports, 1..8.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum cycles to wait for DevAck before an error response.
REQ-003 SHALL take per-device window bases and sizes from the package: bases 0x7F00/0x7F10/0x7F20, size 0xC bytes each.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, async active-high.
REQ-005 PrAddr input 32: CPU byte address.
REQ-006 PrWD input 32: CPU write data.
REQ-007 PrReq input 1: access request, sampled only in IDLE.
REQ-008 PrWE input 1: 1=write, 0=read, qualified by PrReq.
REQ-009 PrRD output 32: read data, valid while PrDone=1.
REQ-010 PrDone output 1: one-cycle completion pulse.
REQ-011 PrErr output 1: error flag, valid while PrDone=1.
REQ-012 PrBusy output 1: high whenever state is not IDLE.
REQ-013 DevAddr output 30: latched word address PrAddr[31:2].
REQ-014 DevWD output 32: latched write data.
REQ-015 DevWE output NDEV: one-hot write strobe.
REQ-016 DevRE output NDEV: one-hot read strobe.
REQ-017 DevRD input 32*NDEV: flattened read data, device i at bits [32i+31:32i].
REQ-018 DevAck input NDEV: per-device completion.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-020 Device i hit SHALL mean BASE[i] <= PrAddr <= BASE[i]+SIZE[i]-1 and PrAddr[1:0]==0; at most one hit is allowed by construction; no hit = miss.
REQ-021 In IDLE with PrReq=1, SHALL latch address, write data, PrWE and the decoded index; a hit SHALL go to ACCESS and a miss SHALL go to RESP.
REQ-022 In ACCESS, SHALL assert exactly one bit of DevWE or DevRE (selected device) for exactly one cycle.
REQ-023 DevAck[sel] SHALL be sampled in ACCESS and WAIT; DevAck of non-selected devices SHALL be ignored.
REQ-024 On ack, SHALL capture DevRD[sel] for reads (0 for writes) and go to RESP with PrErr=0.
REQ-025 Without ack, SHALL stay in WAIT and increment the wait counter (width $clog2(TIMEOUT+1)), which starts at 0 on entry to ACCESS.
REQ-026 When the counter equals TIMEOUT with no ack, SHALL go to RESP with PrErr=1 and PrRD=0.
REQ-027 In RESP, SHALL assert PrDone for one cycle, then return to IDLE; PrErr=1 for a miss or timeout.
REQ-028 PrRD and PrErr SHALL be registered and hold their value until the next RESP.
REQ-029 Latency: request accepted in cycle T, strobe in T+1, ack in T+1 gives PrDone in T+2; a miss gives PrDone in T+1.
REQ-030 PrReq SHALL be ignored outside IDLE; RESP->IDLE followed by a new request SHALL allow back-to-back requests every 3 cycles.
REQ-031 DevAddr and DevWD SHALL be stable from ACCESS through RESP.

Reset
REQ-032 Reset SHALL force IDLE, counter 0, and PrRD/PrDone/PrErr/PrBusy/DevWE/DevRE/DevAddr/DevWD all 0.
REQ-033 Reset mid-ACCESS or mid-WAIT SHALL abort the access: no further strobe and no PrDone.

Structure
REQ-034 Package bridge_pkg SHALL hold the NDEV default, BASE/SIZE arrays, the TIMEOUT default and the state enum.
REQ-035 A combinational sub-module bridge_addr_decode SHALL produce the one-hot hit vector and the miss flag.

Verification
REQ-036 Read 0x7F04 with DevAck[0] given in the ACCESS cycle and DevRD[0]=0xDEADBEEF -> DevRE=001 for 1 cycle; PrDone at T+2 with PrRD=0xDEADBEEF, PrErr=0.
REQ-037 Write 0x7F18, data 0x12345678, DevAck[1] delayed 3 cycles -> DevWE=010 once, DevWD=0x12345678, DevAddr=0x1FC6; PrDone at T+5, PrErr=0.
REQ-038 Read 0x7F30 (miss) and read 0x7F05 (misaligned) -> no strobes; PrDone at T+1, PrErr=1, PrRD=0.
REQ-039 Read 0x7F20 with no ack -> PrDone after TIMEOUT expiry (T+1+15+1), PrErr=1, PrRD=0; PrBusy high throughout.
REQ-040 Assert reset in the WAIT cycle of a pending access, then raise DevAck -> all outputs 0, no PrDone; the next request completes normally.
REQ-041 During WAIT for device 2, pulse DevAck[0] and PrReq -> both ignored; completion occurs only on DevAck[2].
